// File: rtl/booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// booth_radix4_mult
// Sequential radix-4 (modified) Booth multiplier for the FPU mantissa path.
// Retires two multiplier bits per RUN cycle; supports signed and unsigned
// operands selected per operation.
//
// Optional feature macro: BOOTH_ACC_EN (multiply-accumulate). When defined,
// an extra input i_acc selects "o_result <= o_result + product" instead of
// overwrite. The add happens on the RUN->DONE edge, so latency is unchanged.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        synchronous active-high reset
//   i_start      start request, sampled only while o_busy==0
//   i_signed     1 = two's-complement operands, 0 = unsigned
//   i_acc        (BOOTH_ACC_EN only) accumulate into previous o_result
//   i_A, i_B     multiplicand / multiplier, sampled with i_start
//   o_busy       high in RUN
//   o_done       one-cycle pulse in DONE; o_result valid from this cycle
//   o_result     2*WIDTH-bit product, held until the next completed op
//   o_dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a start is accepted on a rising edge where i_start==1 and the
// unit is not in RUN (IDLE or DONE). o_busy is then high for exactly ITER
// cycles and o_done pulses in the following cycle. Starts seen during RUN
// are dropped, not queued. Accepting in DONE gives back-to-back operation.
// -----------------------------------------------------------------------------
module booth_radix4_mult #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
`ifdef BOOTH_ACC_EN
  input  logic               i_acc,
`endif
  input  logic [WIDTH-1:0]   i_A,
  input  logic [WIDTH-1:0]   i_B,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result,
  output logic [1:0]         o_dbg_state
);

  // One RUN cycle per pair of multiplier bits, plus one for the 2 extension bits.
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH+1:0]   m_q, m_d;     // extended multiplicand
  logic [WIDTH+1:0]   q_q, q_d;     // extended multiplier, shifts out to the right
  logic               qm1_q, qm1_d; // Booth guard bit q[-1]
  logic [WIDTH+2:0]   p_q, p_d;     // partial accumulator
  logic [2*WIDTH-1:0] res_q, res_d;
`ifdef BOOTH_ACC_EN
  logic               acc_q, acc_d;
`endif

  logic [WIDTH+2:0]          m1;      // +M sign-extended to P width
  logic [WIDTH+2:0]          m2;      // +2M; fits because M uses only WIDTH+2 bits
  logic [WIDTH+2:0]          digit;
  logic [WIDTH+2:0]          p_sum;
  logic signed [2*WIDTH+5:0] sh_in;
  logic signed [2*WIDTH+5:0] sh_out;
  logic [2*WIDTH-1:0]        prod;
  logic [2*WIDTH-1:0]        res_new;

  assign m1 = {m_q[WIDTH+1], m_q};
  assign m2 = {m_q, 1'b0};

  always_comb begin
    digit = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: digit = m1;
      3'b011:         digit = m2;
      3'b100:         digit = -m2;
      3'b101, 3'b110: digit = -m1;
      default:        digit = '0;
    endcase
  end

  assign p_sum  = p_q + digit;
  assign sh_in  = {p_sum, q_q, qm1_q};
  assign sh_out = sh_in >>> 2;
  // Low 2*WIDTH bits of {P,Q}; bit 0 of sh_out is the guard bit.
  assign prod   = sh_out[2*WIDTH:1];

`ifdef BOOTH_ACC_EN
  assign res_new = acc_q ? (res_q + prod) : prod;  // wraps silently
`else
  assign res_new = prod;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    p_d     = p_q;
    res_d   = res_q;
`ifdef BOOTH_ACC_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          m_d     = i_signed ? {{2{i_A[WIDTH-1]}}, i_A} : {2'b00, i_A};
          q_d     = i_signed ? {{2{i_B[WIDTH-1]}}, i_B} : {2'b00, i_B};
          qm1_d   = 1'b0;
          p_d     = '0;
          cnt_d   = CNT_INIT;
          state_d = S_RUN;
`ifdef BOOTH_ACC_EN
          acc_d   = i_acc;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        p_d   = sh_out[2*WIDTH+5:WIDTH+3];
        q_d   = sh_out[WIDTH+2:1];
        qm1_d = sh_out[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          res_d   = res_new;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      p_q     <= '0;
      res_q   <= '0;
`ifdef BOOTH_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      p_q     <= p_d;
      res_q   <= res_d;
`ifdef BOOTH_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign o_busy      = (state_q == S_RUN);
  assign o_done      = (state_q == S_DONE);
  assign o_result    = res_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_mult
// Directed + random bench for booth_radix4_mult. One WIDTH=8 instance carries
// the directed timing/handshake cases; a WIDTH=32 instance gets random and
// corner operands. Expected products come from plain integer multiplication.
// -----------------------------------------------------------------------------
module tb_booth_radix4_mult;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start8 = 1'b0, sgn8 = 1'b0, acc8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] res8;
  logic [1:0]  dbg8;

  logic        start32 = 1'b0, sgn32 = 1'b0, acc32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] res32;
  logic [1:0]  dbg32;

  booth_radix4_mult #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_signed(sgn8),
`ifdef BOOTH_ACC_EN
    .i_acc(acc8),
`endif
    .i_A(a8), .i_B(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8), .o_dbg_state(dbg8)
  );

  booth_radix4_mult #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start32), .i_signed(sgn32),
`ifdef BOOTH_ACC_EN
    .i_acc(acc32),
`endif
    .i_A(a32), .i_B(b32),
    .o_busy(busy32), .o_done(done32), .o_result(res32), .o_dbg_state(dbg32)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last8  = '0;  // expected held o_result of dut8
  logic [63:0] last32 = '0;  // expected held o_result of dut32

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: extend each operand to a full integer, multiply, keep low bits.
  function automatic logic [63:0] ref_mul(input int w, input bit s,
                                          input logic [31:0] a, input logic [31:0] b);
    longint ax, bx;
    ax = longint'({32'd0, a});
    bx = longint'({32'd0, b});
    if (s && a[w-1]) ax = ax - (longint'(1) << w);
    if (s && b[w-1]) bx = bx - (longint'(1) << w);
    return 64'(ax * bx);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. If the unit is in DONE, the start is back-to-back.
  task automatic do_op8(input bit s, input logic [7:0] av, input logic [7:0] bv,
                        input bit accv, input bit pulse_mid);
    logic [15:0] e;
    int lat;
    e = 16'(ref_mul(8, s, {24'd0, av}, {24'd0, bv}));
    if (accv) e = last8 + e;
    exp_q.push_back({48'd0, e});
    sgn8 = s; a8 = av; b8 = bv; acc8 = accv; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    lat = 1;
    chk("busy_after_accept", {63'd0, busy8}, 64'd1);
    chk("no_early_done", {63'd0, done8}, 64'd0);
    while (!done8 && lat < 20) begin
      if (busy8) chk("result_stable_busy", {48'd0, res8}, {48'd0, last8});
      start8 = (pulse_mid && (lat == 2 || lat == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    chk("latency8", 64'(lat), 64'd6);
    chk("result8", {48'd0, res8}, exp_q.pop_front());
    last8 = e;
  endtask

  task automatic do_op32(input bit s, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] e;
    int lat;
    e = ref_mul(32, s, av, bv);
    exp_q.push_back(e);
    sgn32 = s; a32 = av; b32 = bv; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency32", 64'(lat), 64'd18);
    chk("result32", res32, exp_q.pop_front());
    last32 = e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    bit accr;
    repeat (3) @(negedge clk);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_result8", {48'd0, res8}, 64'd0);
    chk("rst_result32", res32, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Corner products and exact latency.
    do_op8(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    chk("signed_min_min", {48'd0, res8}, 64'h4000);
    @(negedge clk);
    do_op8(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("unsigned_max_max", {48'd0, res8}, 64'hFE01);
    @(negedge clk);
    do_op8(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0);
    // Back-to-back: start issued in the DONE cycle.
    do_op8(1'b1, 8'h03, 8'hFD, 1'b0, 1'b0);
    chk("back_to_back", {48'd0, res8}, 64'hFFF7);

    // Starts during RUN must be ignored.
    @(negedge clk);
    do_op8(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_done", {63'd0, done8}, 64'd0);
    chk("result_held", {48'd0, res8}, {48'd0, last8});

    // Reset mid-RUN discards the operation.
    sgn8 = 1'b1; a8 = 8'h07; b8 = 8'h09; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last8 = '0;
    last32 = '0;
    chk("midrun_rst_busy", {63'd0, busy8}, 64'd0);
    chk("midrun_rst_done", {63'd0, done8}, 64'd0);
    chk("midrun_rst_result", {48'd0, res8}, 64'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("no_done_after_rst", 64'(dones), 64'd0);
    do_op8(1'b1, 8'hF9, 8'h05, 1'b0, 1'b0);

`ifdef BOOTH_ACC_EN
    @(negedge clk);
    do_op8(1'b0, 8'd3, 8'd4, 1'b0, 1'b0);
    chk("acc_first", {48'd0, res8}, 64'h000C);
    do_op8(1'b0, 8'd5, 8'd6, 1'b1, 1'b0);
    chk("acc_second", {48'd0, res8}, 64'h002A);
`endif

    // Random 8-bit operations, some back-to-back.
    for (int i = 0; i < 24; i++) begin
`ifdef BOOTH_ACC_EN
      accr = 1'($urandom_range(0, 1));
`else
      accr = 1'b0;
`endif
      do_op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), accr, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // WIDTH=32 corners and random operands.
    do_op32(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("w32_signed_min_min", res32, 64'h4000_0000_0000_0000);
    do_op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("w32_unsigned_max_max", res32, 64'hFFFF_FFFE_0000_0001);
    for (int i = 0; i < 16; i++) begin
      do_op32(1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
